lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Panel-side responder for the 16-bit 8080-style write bus (CSX/DCX/WRX/RWX/data_lcd) that our LCD controller drives.
- Samples bus writes and decodes the ILI9341-style command set: 0x2A/0x2B windowing, 0x2C memory write, 0x36, 0x11/0x10, 0x29/0x28.
- Emits linear frame-buffer pixel writes plus panel status flags.
- Used as a synthesizable panel model for on-board loopback capture and as the bus checker in system simulation.

Parameters:
- H_RES, 240, columns per line; column addresses 0..H_RES-1.
- V_RES, 320, lines per frame; page addresses 0..V_RES-1.
- ADDR_W, 17, width of pix_addr; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- CSX  in  1  chip select, active low.
- DCX  in  1  0 = command word, 1 = parameter/pixel word.
- WRX  in  1  write strobe; data is taken on its rising edge.
- RWX  in  1  read strobe; reads are unsupported.
- data_lcd  in  16  bus data.
- pix_we  out  1  one-cycle pixel write strobe.
- pix_addr  out  ADDR_W  page*H_RES + col.
- pix_data  out  16  RGB565 pixel.
- cmd_valid  out  1  one-cycle pulse per command word.
- cmd_code  out  8  last command byte.
- madctl  out  8  last 0x36 parameter.
- sleep_out  out  1  1 after 0x11, 0 after 0x10.
- disp_on  out  1  1 after 0x29, 0 after 0x28.
- frame_done  out  1  one-cycle pulse when a window fill completes.
- bus_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs 0. Window SC=0, EC=H_RES-1, SP=0, EP=V_RES-1. col/page pointers 0. State IDLE.
- Input capture: CSX, DCX, WRX, RWX, data_lcd each pass through the same 2-flop synchronizer (s1, s2), plus a third WRX flop s3.
- Write event: wrx_s2 & ~wrx_s3 & ~csx_s2. Event DCX/data are the s2 values.
- Event latency: all outputs are registered on the edge after event detection, i.e. visible after the 3rd sys_clk rising edge that samples WRX=1.
- An event with rwx_s2=0 is ignored and sets bus_err.
- WRX edges while CSX is high are ignored.
- States: IDLE, PARAM, MEMWR.
- Command (DCX=0), accepted in any state:
  - cmd_code <= data[7:0]; cmd_valid pulses; param index <= 0.
  - 0x2A or 0x2B -> PARAM, expecting 4 params.
  - 0x36 -> PARAM, expecting 1 param.
  - 0x2C -> col<=SC, page<=SP, then MEMWR. If SC>EC or SP>EP, set bus_err and go to IDLE instead.
  - 0x11/0x10 set/clear sleep_out; 0x29/0x28 set/clear disp_on. These four go to IDLE.
  - Any other code -> PARAM with 0 expected params; its params are discarded.
- PARAM state (DCX=1): params are taken as data[7:0] in order.
  - 0x2A: SC[15:8], SC[7:0], EC[15:8], EC[7:0].
  - 0x2B: the same order for SP, EP.
  - The new window takes effect on the 4th param. If fewer than 4 params arrive before the next command, the window is unchanged.
  - 0x36: param -> madctl.
  - Params beyond the expected count are discarded silently.
- MEMWR state (DCX=1 word):
  - pix_data <= data; pix_addr <= page*H_RES+col; pix_we pulses, unless col>=H_RES or page>=V_RES (write suppressed, pointer still advances).
  - Pointer step: if col!=EC, col++. Else col<=SC and, if page!=EP, page++.
  - If col==EC and page==EP: pointers wrap to SC/SP, frame_done pulses with that last pixel's pix_we, and the state stays MEMWR (further words overwrite from the window start).
- CSX deassert (csx_s2 rising) from any state -> IDLE. Data words in IDLE are ignored.
- Simultaneous events cannot occur: one write event per detection cycle.
- Reset mid-transfer returns everything to reset values immediately (asynchronous). The first command after reset is decoded normally.
- madctl is stored only; it does not change address mapping.
- bus_err clears only on reset.

Test Plan:
- Controller init plus full-screen fill: 0x36/0x00, 0x2A 00 00 00 EF, 0x2B 00 00 01 3F, 0x2C, then 76807 pixel words (value = index).
  - Required: 76807 pix_we pulses.
  - Word 0 -> addr 0; word 239 -> addr 239; word 240 -> addr 240; word 76799 -> addr 76799 with frame_done.
  - Words 76800..76806 -> addr 0..6.
- Sub-window: 0x2A 00 0A 00 0B, 0x2B 00 05 00 06, 0x2C, 4 pixels.
  - Required addrs 1210, 1211, 1450, 1451; frame_done on the 4th pixel.
- Status commands: 0x11 then 0x29.
  - Required: sleep_out=1, then disp_on=1, each with cmd_valid and matching cmd_code.
  - Then 0x28 -> disp_on=0.
- Latency: single 0x2C then one pixel with WRX rising mid-cycle.
  - Required: pix_we asserted exactly 3 sys_clk edges after WRX is first sampled high.
  - CSX pulled high between words -> second word ignored.
- Errors:
  - 0x2A 00 20 00 10, then 0x2C -> bus_err=1, no pix_we on following data words.
  - A write with RWX=0 -> bus_err=1.
- Reset mid-MEMWR after 100 pixels -> all outputs 0, window back to full screen; a new 0x2C starts at addr 0.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: panel-side model of an ILI9341-style 16-bit 8080 write bus.
// Synchronizes the bus, decodes windowing / memory-write / status commands and
// turns memory-write data words into linear frame-buffer pixel writes.
//
// Ports:
//   sys_clk, sys_rst_n       clock, async active-low reset
//   CSX, DCX, WRX, RWX       8080 bus strobes (asynchronous to sys_clk)
//   data_lcd[15:0]           bus data
//   pix_we/pix_addr/pix_data one-cycle pixel write, addr = page*H_RES + col
//   cmd_valid/cmd_code       one-cycle pulse and byte of each command word
//   madctl                   last 0x36 parameter (stored only)
//   sleep_out, disp_on       panel status flags
//   frame_done               pulse with the last pixel of a window fill
//   bus_err                  sticky protocol-error flag
//
// state | meaning
// IDLE  | no command in progress; data words are ignored
// PARAM | collecting parameters of the last command
// MEMWR | data words are pixels written at the col/page pointers
module lcd_bus_responder #(
  parameter int H_RES  = 240,
  parameter int V_RES  = 320,
  parameter int ADDR_W = 17
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              CSX,
  input  logic              DCX,
  input  logic              WRX,
  input  logic              RWX,
  input  logic [15:0]       data_lcd,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [15:0]       pix_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic [7:0]        madctl,
  output logic              sleep_out,
  output logic              disp_on,
  output logic              frame_done,
  output logic              bus_err
);

  localparam logic [15:0]       H_LIM   = 16'(H_RES);
  localparam logic [15:0]       V_LIM   = 16'(V_RES);
  localparam logic [15:0]       EC_RST  = 16'(H_RES - 1);
  localparam logic [15:0]       EP_RST  = 16'(V_RES - 1);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  typedef enum logic [1:0] {IDLE, PARAM, MEMWR} state_t;

  logic        csx_s1, csx_s2, csx_s3;
  logic        dcx_s1, dcx_s2;
  logic        wrx_s1, wrx_s2, wrx_s3;
  logic        rwx_s1, rwx_s2;
  logic [15:0] dat_s1, dat_s2;

  // Strobes reset to their inactive level so a bus already idling high
  // after reset does not look like a fresh WRX edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csx_s1 <= 1'b1;
      csx_s2 <= 1'b1;
      csx_s3 <= 1'b1;
      dcx_s1 <= 1'b0;
      dcx_s2 <= 1'b0;
      wrx_s1 <= 1'b1;
      wrx_s2 <= 1'b1;
      wrx_s3 <= 1'b1;
      rwx_s1 <= 1'b1;
      rwx_s2 <= 1'b1;
      dat_s1 <= '0;
      dat_s2 <= '0;
    end else begin
      csx_s1 <= CSX;
      csx_s2 <= csx_s1;
      csx_s3 <= csx_s2;
      dcx_s1 <= DCX;
      dcx_s2 <= dcx_s1;
      wrx_s1 <= WRX;
      wrx_s2 <= wrx_s1;
      wrx_s3 <= wrx_s2;
      rwx_s1 <= RWX;
      rwx_s2 <= rwx_s1;
      dat_s1 <= data_lcd;
      dat_s2 <= dat_s1;
    end
  end

  logic wr_evt, csx_rise;
  assign wr_evt   = wrx_s2 & ~wrx_s3 & ~csx_s2;
  assign csx_rise = csx_s2 & ~csx_s3;

  state_t      state;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] col, page;
  logic [2:0]  par_idx;
  logic [2:0]  par_cnt;
  logic [7:0]  sh_hi;
  logic [15:0] sh_start;

  always_comb begin
    par_cnt = 3'd0;
    case (cmd_code)
      8'h2A, 8'h2B: par_cnt = 3'd4;
      8'h36:        par_cnt = 3'd1;
      default:      ;
    endcase
  end

  logic [ADDR_W-1:0] lin_addr;
  logic              pix_in_range;
  assign lin_addr     = ADDR_W'(page) * H_RES_A + ADDR_W'(col);
  assign pix_in_range = (col < H_LIM) && (page < V_LIM);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      madctl     <= '0;
      sleep_out  <= 1'b0;
      disp_on    <= 1'b0;
      frame_done <= 1'b0;
      bus_err    <= 1'b0;
      sc         <= '0;
      ec         <= EC_RST;
      sp         <= '0;
      ep         <= EP_RST;
      col        <= '0;
      page       <= '0;
      par_idx    <= '0;
      sh_hi      <= '0;
      sh_start   <= '0;
    end else begin
      pix_we     <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (csx_rise) begin
        state <= IDLE;
      end else if (wr_evt) begin
        if (!rwx_s2) begin
          bus_err <= 1'b1;
        end else if (!dcx_s2) begin
          cmd_code  <= dat_s2[7:0];
          cmd_valid <= 1'b1;
          par_idx   <= '0;
          case (dat_s2[7:0])
            8'h2C: begin
              if (sc > ec || sp > ep) begin
                bus_err <= 1'b1;
                state   <= IDLE;
              end else begin
                col   <= sc;
                page  <= sp;
                state <= MEMWR;
              end
            end
            8'h11: begin sleep_out <= 1'b1; state <= IDLE; end
            8'h10: begin sleep_out <= 1'b0; state <= IDLE; end
            8'h29: begin disp_on   <= 1'b1; state <= IDLE; end
            8'h28: begin disp_on   <= 1'b0; state <= IDLE; end
            default: state <= PARAM;
          endcase
        end else begin
          case (state)
            PARAM: begin
              if (par_idx < par_cnt) begin
                par_idx <= par_idx + 3'd1;
                if (cmd_code == 8'h36) begin
                  madctl <= dat_s2[7:0];
                end else begin
                  // Window registers only change on the 4th byte so a
                  // truncated sequence leaves the old window intact.
                  case (par_idx)
                    3'd0, 3'd2: sh_hi    <= dat_s2[7:0];
                    3'd1:       sh_start <= {sh_hi, dat_s2[7:0]};
                    3'd3: begin
                      if (cmd_code == 8'h2A) begin
                        sc <= sh_start;
                        ec <= {sh_hi, dat_s2[7:0]};
                      end else begin
                        sp <= sh_start;
                        ep <= {sh_hi, dat_s2[7:0]};
                      end
                    end
                    default: ;
                  endcase
                end
              end
            end
            MEMWR: begin
              pix_data <= dat_s2;
              pix_addr <= lin_addr;
              pix_we   <= pix_in_range;
              if (col != ec) begin
                col <= col + 16'd1;
              end else begin
                col <= sc;
                if (page != ep) begin
                  page <= page + 16'd1;
                end else begin
                  page       <= sp;
                  frame_done <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        CSX = 1'b1, DCX = 1'b1, WRX = 1'b1, RWX = 1'b1;
  logic [15:0] data_lcd = 16'h0000;

  logic        pix_we, cmd_valid, sleep_out, disp_on, frame_done, bus_err;
  logic [16:0] pix_addr;
  logic [15:0] pix_data;
  logic [7:0]  cmd_code, madctl;

  lcd_bus_responder #(.H_RES(240), .V_RES(320), .ADDR_W(17)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .CSX(CSX), .DCX(DCX), .WRX(WRX), .RWX(RWX), .data_lcd(data_lcd),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .madctl(madctl),
    .sleep_out(sleep_out), .disp_on(disp_on), .frame_done(frame_done),
    .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
    logic        fd;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] cmd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin : monitor
    pix_t       e;
    logic [7:0] c;
    if (sys_rst_n) begin
      if (pix_we) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected actual=write addr %0d required=no write", pix_addr);
        end else begin
          e = pix_q.pop_front();
          check("pix_addr", 32'(pix_addr), 32'(e.addr));
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_alone actual=1 required=0");
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected actual=0x%0h required=no command", cmd_code);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_code", 32'(cmd_code), 32'(c));
        end
      end
    end
  end

  task automatic bus_write(input logic dc, input logic [15:0] d, input logic rw);
    CSX = 1'b0; DCX = dc; data_lcd = d; RWX = rw; WRX = 1'b0;
    repeat (2) @(negedge sys_clk);
    WRX = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic cmd(input logic [7:0] c);
    cmd_q.push_back(c);
    bus_write(1'b0, {8'h00, c}, 1'b1);
  endtask

  task automatic par(input logic [7:0] p);
    bus_write(1'b1, {8'h00, p}, 1'b1);
  endtask

  task automatic pix(input logic [16:0] a, input logic [15:0] d, input logic fd);
    pix_q.push_back('{addr: a, data: d, fd: fd});
    bus_write(1'b1, d, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pix_q.size() != 0 || cmd_q.size() != 0) && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    check({name, "_pix_pending"}, 32'(pix_q.size()), 32'd0);
    check({name, "_cmd_pending"}, 32'(cmd_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_flags"}, 32'({pix_we, cmd_valid, frame_done, sleep_out, disp_on, bus_err}), 32'd0);
    check({name, "_pix_addr"}, 32'(pix_addr), 32'd0);
    check({name, "_pix_data"}, 32'(pix_data), 32'd0);
    check({name, "_cmd_code"}, 32'(cmd_code), 32'd0);
    check({name, "_madctl"}, 32'(madctl), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  int sub_addr[4] = '{1210, 1211, 1450, 1451};

  initial begin
    repeat (3) @(negedge sys_clk);
    check_reset("por");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // status commands
    cmd(8'h11); drain("sleep");
    check("sleep_out_set", 32'(sleep_out), 32'd1);
    cmd(8'h29); drain("disp");
    check("disp_on_set", 32'(disp_on), 32'd1);
    check("sleep_out_hold", 32'(sleep_out), 32'd1);
    cmd(8'h28); drain("disp_off");
    check("disp_on_clr", 32'(disp_on), 32'd0);

    // madctl, with an extra parameter that must be discarded
    cmd(8'h36); par(8'h48); par(8'h99); drain("madctl");
    check("madctl", 32'(madctl), 32'h48);

    // full-screen window, head of the fill (row wrap at 239 -> 240)
    cmd(8'h2A); par(8'h00); par(8'h00); par(8'h00); par(8'hEF);
    cmd(8'h2B); par(8'h00); par(8'h00); par(8'h01); par(8'h3F);
    cmd(8'h2C);
    for (int i = 0; i < 481; i++) pix(17'(i), 16'(i), 1'b0);
    drain("full_head");

    // last four lines: ends at 76799 with frame_done, then wraps to 316*240
    cmd(8'h2B); par(8'h01); par(8'h3C); par(8'h01); par(8'h3F);
    cmd(8'h2C);
    for (int i = 0; i < 967; i++) begin
      if (i < 960) pix(17'(75840 + i), 16'(i), (i == 959));
      else         pix(17'(75840 + i - 960), 16'(i), 1'b0);
    end
    drain("full_tail");

    // sub-window 10..11 x 5..6
    cmd(8'h2A); par(8'h00); par(8'h0A); par(8'h00); par(8'h0B);
    cmd(8'h2B); par(8'h00); par(8'h05); par(8'h00); par(8'h06);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) pix(17'(sub_addr[i]), 16'(16'hA000 + i), (i == 3));
    drain("subwin");

    // truncated 0x2A keeps the window; latency of a single pixel
    cmd(8'h2A); par(8'h00); par(8'h00);
    cmd(8'h2C);
    drain("trunc");
    pix_q.push_back('{addr: 17'd1210, data: 16'hABCD, fd: 1'b0});
    CSX = 1'b0; DCX = 1'b1; data_lcd = 16'hABCD; RWX = 1'b1; WRX = 1'b0;
    repeat (2) @(negedge sys_clk);
    WRX = 1'b1;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    check("lat_edge2_we", 32'(pix_we), 32'd0);
    @(posedge sys_clk); #1;
    check("lat_edge3_we", 32'(pix_we), 32'd1);
    @(negedge sys_clk);

    // CSX high between words: following word is ignored
    CSX = 1'b1;
    repeat (4) @(negedge sys_clk);
    bus_write(1'b1, 16'h5555, 1'b1);
    drain("csx_ignore");

    // read-strobe protocol error
    check("bus_err_pre", 32'(bus_err), 32'd0);
    bus_write(1'b1, 16'h1234, 1'b0);
    repeat (3) @(negedge sys_clk);
    check("bus_err_rwx", 32'(bus_err), 32'd1);

    // inverted window error
    pulse_reset();
    check("bus_err_cleared", 32'(bus_err), 32'd0);
    cmd(8'h2A); par(8'h00); par(8'h20); par(8'h00); par(8'h10);
    cmd(8'h2C);
    for (int i = 0; i < 3; i++) bus_write(1'b1, 16'(16'hE000 + i), 1'b1);
    drain("bad_window");
    check("bus_err_window", 32'(bus_err), 32'd1);

    // reset during a memory write
    pulse_reset();
    cmd(8'h2C);
    for (int i = 0; i < 100; i++) pix(17'(i), 16'(16'h100 + i), 1'b0);
    drain("pre_reset");
    sys_rst_n = 1'b0;
    #1;
    check_reset("mid_memwr");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    cmd(8'h2C);
    for (int i = 0; i < 241; i++) pix(17'(i), 16'(16'h200 + i), 1'b0);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
